window_line_buffer: RTL and testbench



---
 rtl/window_line_buffer.sv | 129 ++++++++++++
 tb/tb_window_line_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// Single-line pixel ring buffer that emits a KERNEL_SIZE-tap horizontal window per read.
// Define WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN to clamp taps at the line end instead of wrapping.
module window_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 512,
  parameter int KERNEL_SIZE = 3,
  localparam int CNT_WIDTH  = $clog2(LINE_WIDTH + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_flush,
  input  logic [PIXEL_WIDTH-1:0]             i_data,
  input  logic                               i_data_valid,
  input  logic                               i_rd_data,
  output logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] o_data,
  output logic                               o_data_valid,
  output logic [CNT_WIDTH-1:0]               o_count,
  output logic                               o_empty,
  output logic                               o_full,
  output logic                               o_overflow,
  output logic                               o_underflow
);

  localparam int AW = $clog2(LINE_WIDTH);
  localparam int DW = KERNEL_SIZE * PIXEL_WIDTH;

  logic [PIXEL_WIDTH-1:0] r_mem [LINE_WIDTH];
  logic [AW-1:0]          r_wr_addr;
  logic [AW-1:0]          r_rd_addr;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [DW-1:0]          r_data;
  logic                   r_valid;
  logic                   r_ovf;
  logic                   r_udf;

  logic [CNT_WIDTH-1:0]   w_need;
  logic                   w_run;
  logic                   w_rd_ok;
  logic                   w_wr_ok;
  logic [DW-1:0]          w_taps;
  logic [AW:0]            w_sum;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] a);
    return (a == AW'(LINE_WIDTH - 1)) ? '0 : a + AW'(1);
  endfunction

`ifdef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
  logic [CNT_WIDTH-1:0] w_rem;

  // Near the line end fewer fresh pixels are needed since taps clamp.
  assign w_rem  = CNT_WIDTH'(LINE_WIDTH) - CNT_WIDTH'(r_rd_addr);
  assign w_need = (w_rem < CNT_WIDTH'(KERNEL_SIZE)) ?
                  w_rem : CNT_WIDTH'(KERNEL_SIZE);
`else
  assign w_need = CNT_WIDTH'(KERNEL_SIZE);
`endif

  assign w_run   = i_rst_n && !i_flush;
  assign w_rd_ok = w_run && i_rd_data && (r_count >= w_need);
  assign w_wr_ok = w_run && i_data_valid &&
                   ((r_count < CNT_WIDTH'(LINE_WIDTH)) || w_rd_ok);

  always_comb begin
    w_taps = '0;
    w_sum  = '0;
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      w_sum = {1'b0, r_rd_addr} + (AW+1)'(j);
`ifdef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
      if (w_sum > (AW+1)'(LINE_WIDTH - 1))
        w_sum = (AW+1)'(LINE_WIDTH - 1);
`else
      if (w_sum >= (AW+1)'(LINE_WIDTH))
        w_sum = w_sum - (AW+1)'(LINE_WIDTH);
`endif
      w_taps[j*PIXEL_WIDTH +: PIXEL_WIDTH] = r_mem[w_sum[AW-1:0]];
    end
  end

  // Memory is never cleared; taps above see pre-write contents on collision.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok)
      r_mem[r_wr_addr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else if (i_flush) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_data    <= w_taps;
        r_rd_addr <= f_inc(r_rd_addr);
      end
      if (w_wr_ok)
        r_wr_addr <= f_inc(r_wr_addr);
      if (i_data_valid && !w_wr_ok)
        r_ovf <= 1'b1;
      if (i_rd_data && !w_rd_ok)
        r_udf <= 1'b1;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_count      = r_count;
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CNT_WIDTH'(LINE_WIDTH));
  assign o_overflow   = r_ovf;
  assign o_underflow  = r_udf;

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer at LINE_WIDTH=8, KERNEL_SIZE=3.
// Replicate-mode scenario runs when WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN is defined.
module tb_window_line_buffer;

  localparam int PW = 8;
  localparam int LW = 8;
  localparam int K  = 3;
  localparam int CW = $clog2(LW + 1);

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic [PW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          i_rd_data = 1'b0;
  logic [K*PW-1:0] o_data;
  logic          o_data_valid;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_overflow;
  logic          o_underflow;

  window_line_buffer #(
    .PIXEL_WIDTH(PW),
    .LINE_WIDTH (LW),
    .KERNEL_SIZE(K)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .i_rd_data   (i_rd_data),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [PW-1:0]   m_mem [LW];
  int              m_wr, m_rd, m_cnt;
  logic            m_ovf, m_udf, m_vld;
  logic [K*PW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input logic wr, input logic [PW-1:0] d,
                      input logic rd, input logic fl, input logic rst);
    int need, a;
    logic rok, wok;
    logic [K*PW-1:0] win;
    @(negedge clk);
    i_data_valid = wr;
    i_data       = d;
    i_rd_data    = rd;
    i_flush      = fl;
    i_rst_n      = rst;
    if (!rst || fl) begin
      m_wr = 0; m_rd = 0; m_cnt = 0;
      m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
`ifdef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
      need = (LW - m_rd < K) ? LW - m_rd : K;
`else
      need = K;
`endif
      rok = rd && (m_cnt >= need);
      wok = wr && (m_cnt < LW || rok);
      m_vld = rok;
      if (rok) begin
        for (int j = 0; j < K; j++) begin
          a = m_rd + j;
`ifdef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
          if (a > LW - 1) a = LW - 1;
`else
          a = a % LW;
`endif
          win[j*PW +: PW] = m_mem[a];
        end
        sb.push_back(win);
        m_rd = (m_rd + 1) % LW;
      end
      if (wok) begin
        m_mem[m_wr] = d;
        m_wr = (m_wr + 1) % LW;
      end
      if (wr && !wok) m_ovf = 1;
      if (rd && !rok) m_udf = 1;
      m_cnt = m_cnt + int'(wok) - int'(rok);
    end
    @(posedge clk);
    #1;
    chk("valid", o_data_valid, m_vld);
    if (o_data_valid) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("window", o_data, sb.pop_front());
    end
    chk("count", o_count, m_cnt);
    chk("empty", o_empty, m_cnt == 0);
    chk("full", o_full, m_cnt == LW);
    chk("ovf", o_overflow, m_ovf);
    chk("udf", o_underflow, m_udf);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic fill(input int n, input logic [PW-1:0] base);
    for (int i = 0; i < n; i++) step(1, base + PW'(i), 0, 0, 1);
  endtask

  initial begin
    do_reset();
    chk("rst_data", o_data, 0);
    chk("rst_empty", o_empty, 1);

    // scenario 1
    fill(8, 8'h10);
    chk("s1_full", o_full, 1);
    chk("s1_count", o_count, 8);
    step(0, 0, 1, 0, 1);
    chk("s1_w0", o_data, 24'h121110);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
    chk("s1_w5", o_data, 24'h171615);
    chk("s1_cnt2", o_count, 2);

`ifndef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
    // scenario 2
    step(0, 0, 1, 0, 1);
    chk("s2_udf", o_underflow, 1);
    chk("s2_novld", o_data_valid, 0);
    chk("s2_hold", o_data, 24'h171615);
    step(1, 8'h20, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("s2_wrap", o_data, 24'h201716);
`endif

    // scenario 3
    do_reset();
    fill(9, 8'h10);
    chk("s3_ovf", o_overflow, 1);
    chk("s3_count", o_count, 8);
    step(0, 0, 1, 0, 1);
    chk("s3_w0", o_data, 24'h121110);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
    chk("s3_w5", o_data, 24'h171615);

    // scenario 4
    do_reset();
    fill(8, 8'h10);
    step(1, 8'h30, 1, 0, 1);
    chk("s4_data", o_data, 24'h121110);
    chk("s4_count", o_count, 8);
    chk("s4_ovf", o_overflow, 0);
    step(0, 0, 1, 0, 1);
    chk("s4_next", o_data, 24'h131211);

    // scenario 5: flush
    do_reset();
    step(0, 0, 1, 0, 1);
    chk("s5_udf_pre", o_underflow, 1);
    fill(5, 8'h10);
    step(0, 0, 1, 0, 1);
    step(1, 8'h55, 1, 1, 1);
    chk("s5f_count", o_count, 0);
    chk("s5f_empty", o_empty, 1);
    chk("s5f_udf", o_underflow, 0);
    chk("s5f_novld", o_data_valid, 0);
    chk("s5f_keep", o_data, 24'h121110);

    // scenario 5: reset mid-line
    do_reset();
    step(0, 0, 1, 0, 1);
    fill(5, 8'h10);
    step(0, 0, 1, 0, 1);
    chk("s5r_pre", o_data, 24'h121110);
    step(1, 8'h55, 1, 0, 0);
    chk("s5r_count", o_count, 0);
    chk("s5r_empty", o_empty, 1);
    chk("s5r_udf", o_underflow, 0);
    chk("s5r_novld", o_data_valid, 0);
    chk("s5r_data", o_data, 0);

`ifdef WINDOW_LINE_BUFFER_EDGE_REPLICATE_EN
    // scenario 6
    do_reset();
    fill(8, 8'h10);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("s6_w6", o_data, 24'h171716);
    step(0, 0, 1, 0, 1);
    chk("s6_w7", o_data, 24'h171717);
    chk("s6_empty", o_empty, 1);
    chk("s6_udf", o_underflow, 0);
`endif

    step(0, 0, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
